tiled_dot_product: RTL and testbench

//  Sequential, pipelined, parametrised dot-product engine for the NPU datapath.
//  - Consumes a pair of signed vectors of run-time length (1..MAX_LEN) as a stream of LANES-wide chunks.
//  - Returns one ACC_WIDTH signed result per job, with overflow reporting and optional saturation.
//  - Replaces the single-cycle combinational N-element dot product for long vectors and backpressured streams.

---
 rtl/tiled_dot_product.sv | 173 +++++++++++++++++
 tb/tb_tiled_dot_product.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiled_dot_product.sv
// Streaming signed dot-product engine: LANES-wide chunks, 3-stage pipeline,
// per-job accumulator with overflow flag and optional saturation.
module tiled_dot_product #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 4,
  parameter int MAX_LEN    = 64,
  parameter int SATURATE   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(MAX_LEN+1)-1:0]  cfg_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_x,
  input  logic [LANES*DATA_WIDTH-1:0]   in_w,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_dp,
  output logic                          out_ovf
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int RW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = 2*DATA_WIDTH;
  localparam int SW = PW + $clog2(LANES);
  localparam int AW = ((ACC_WIDTH > SW) ? ACC_WIDTH : SW) + 1;
  localparam int VW = LANES*DATA_WIDTH;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t state;

  logic [LW-1:0] cnt;
  logic [RW-1:0] rem;

  logic          s0_v, s1_v, s2_v;
  logic [VW-1:0] s0_x, s0_w;
  logic signed [PW-1:0] s1_p [LANES];
  logic signed [SW-1:0] s2_sum;

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        ovf;

  logic [LW-1:0]               len_c;
  logic                        accept;
  logic                        last;
  logic [VW-1:0]               x_m;
  logic signed [SW-1:0]        sum;
  logic signed [AW-1:0]        ext;
  logic                        ext_ovf;
  logic signed [ACC_WIDTH-1:0] acc_nxt;

  always_comb begin
    len_c = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
    accept = in_valid && in_ready;
    last = (cnt == LW'(1));
    // zeroing x in masked lanes forces their product to 0
    x_m = in_x;
    for (int i = 0; i < LANES; i++) begin
      if (last && rem != '0 && i >= int'(rem)) begin
        x_m[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SW'(s1_p[i]);
    end
    // widened sum: any bits above the ACC sign bit disagreeing = overflow
    ext = AW'(acc) + AW'(s2_sum);
    ext_ovf = (ext[AW-1:ACC_WIDTH-1] != '0) &&
              (ext[AW-1:ACC_WIDTH-1] != '1);
    acc_nxt = ext[ACC_WIDTH-1:0];
    if (ext_ovf && SATURATE != 0) begin
      acc_nxt = ext[AW-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      s0_v      <= 1'b0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
    end else begin
      s0_v <= accept;
      if (accept) begin
        s0_x <= x_m;
        s0_w <= in_w;
      end
      s1_v <= s0_v;
      if (s0_v) begin
        for (int i = 0; i < LANES; i++) begin
          s1_p[i] <=
            PW'($signed(s0_x[i*DATA_WIDTH +: DATA_WIDTH])) *
            PW'($signed(s0_w[i*DATA_WIDTH +: DATA_WIDTH]));
        end
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sum <= sum;
      end
      if (s2_v) begin
        acc <= acc_nxt;
        if (ext_ovf) begin
          ovf <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= LW'((32'(len_c) + LANES - 1) / LANES);
            rem       <= RW'(32'(len_c) % LANES);
            cfg_ready <= 1'b0;
            if (len_c == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt - LW'(1);
            if (last) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // last chunk is in the sum stage and lands this edge
          if (!s0_v && !s1_v && s2_v) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_dp  = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_tiled_dot_product.sv
// Randomised scoreboard bench: three engines (32b sat, 16b sat, 16b wrap)
// driven in lockstep and compared against a chunk-level integer model.
module tb_tiled_dot_product;

  localparam int DW      = 8;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 64;
  localparam int LW      = $clog2(MAX_LEN+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_valid = 1'b0;
  logic [LW-1:0]     cfg_len = '0;
  logic              in_valid = 1'b0;
  logic [LANES*DW-1:0] in_x = '0;
  logic [LANES*DW-1:0] in_w = '0;
  logic              out_ready = 1'b0;

  logic cr [3];
  logic ir [3];
  logic ov [3];
  logic oo [3];
  logic signed [31:0] od0;
  logic signed [15:0] od1;
  logic signed [15:0] od2;

  tiled_dot_product #(
    .DATA_WIDTH(DW), .ACC_WIDTH(32), .LANES(LANES),
    .MAX_LEN(MAX_LEN), .SATURATE(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cr[0]), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_x(in_x), .in_w(in_w),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_dp(od0), .out_ovf(oo[0])
  );

  tiled_dot_product #(
    .DATA_WIDTH(DW), .ACC_WIDTH(16), .LANES(LANES),
    .MAX_LEN(MAX_LEN), .SATURATE(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cr[1]), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_x(in_x), .in_w(in_w),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_dp(od1), .out_ovf(oo[1])
  );

  tiled_dot_product #(
    .DATA_WIDTH(DW), .ACC_WIDTH(16), .LANES(LANES),
    .MAX_LEN(MAX_LEN), .SATURATE(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cr[2]), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(ir[2]),
    .in_x(in_x), .in_w(in_w),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_dp(od2), .out_ovf(oo[2])
  );

  typedef struct packed {
    longint d0;
    longint d1;
    longint d2;
    logic   o0;
    logic   o1;
    logic   o2;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q [$];
  int   xv [MAX_LEN+LANES];
  int   wv [MAX_LEN+LANES];
  int   force_hold = -1;
  bit   taken = 1'b0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic stop(string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench aborted");
  endtask

  // Chunk-by-chunk reference: exact integer sums, then range handling
  function automatic exp_t model(int len);
    int     n = (len > MAX_LEN) ? MAX_LEN : len;
    int     aw [3] = '{32, 16, 16};
    bit     sat [3] = '{1'b1, 1'b1, 1'b0};
    longint a [3] = '{0, 0, 0};
    bit     o [3] = '{1'b0, 1'b0, 1'b0};
    longint s, hi, lo;
    exp_t   e;
    for (int c = 0; c*LANES < n; c++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        if (c*LANES + l < n)
          s += longint'(xv[c*LANES+l]) * longint'(wv[c*LANES+l]);
      end
      for (int v = 0; v < 3; v++) begin
        hi = (longint'(1) << (aw[v]-1)) - 1;
        lo = -hi - 1;
        a[v] += s;
        if (a[v] > hi || a[v] < lo) begin
          o[v] = 1'b1;
          if (sat[v]) begin
            a[v] = (a[v] > hi) ? hi : lo;
          end else begin
            while (a[v] > hi) a[v] -= 2*(hi+1);
            while (a[v] < lo) a[v] += 2*(hi+1);
          end
        end
      end
    end
    e.d0 = a[0]; e.d1 = a[1]; e.d2 = a[2];
    e.o0 = o[0]; e.o1 = o[1]; e.o2 = o[2];
    return e;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < MAX_LEN+LANES; i++) begin
      xv[i] = int'($urandom_range(255)) - 128;
      wv[i] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_cfg_ready"}, longint'(cr[0]), 1);
    chk({tag, "_in_ready"}, longint'(ir[0]), 0);
    chk({tag, "_out_valid"}, longint'(ov[0]), 0);
    chk({tag, "_out_dp"}, longint'(od0), 0);
    chk({tag, "_out_ovf"}, longint'(oo[0]), 0);
  endtask

  task automatic run_job(int len, int gap, int abort_at, int hold);
    int n, nch, bud, lat, seen;
    bit ok;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    nch = (n + LANES - 1) / LANES;
    @(negedge clk);
    force_hold = hold;
    bud = 0;
    while (cr[0] !== 1'b1) begin
      if (bud > 500) stop("cfg_ready_wait");
      @(negedge clk);
      bud++;
    end
    cfg_valid = 1'b1;
    cfg_len = LW'(len);
    q.push_back(model(len));
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int c = 0; c < nch; c++) begin
      if (c == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(q.pop_back());
        check_reset_outputs("midrst");
        seen = 0;
        repeat (6) begin
          @(negedge clk);
          if (ov[0] === 1'b1) seen = 1;
        end
        chk("midrst_no_partial", seen, 0);
        return;
      end
      bud = 0;
      forever begin
        if (int'($urandom_range(99)) < gap) begin
          in_valid = 1'b0;
          in_x = $urandom;
          in_w = $urandom;
          ok = 1'b0;
        end else begin
          in_valid = 1'b1;
          for (int l = 0; l < LANES; l++) begin
            in_x[l*DW +: DW] = 8'(xv[c*LANES+l]);
            in_w[l*DW +: DW] = 8'(wv[c*LANES+l]);
          end
          ok = (ir[0] === 1'b1);
        end
        @(negedge clk);
        if (ok) break;
        bud++;
        if (bud > 300) stop("in_ready_wait");
      end
    end
    in_valid = 1'b0;
    lat = 0;
    while (ov[0] !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (nch > 0) chk("latency_last_chunk", lat, 3);
    else chk("latency_len0_le2", longint'(lat <= 2), 1);
  endtask

  // Monitor: pop and compare on each presented result, random backpressure
  initial begin
    exp_t e;
    int   hold;
    forever begin
      @(negedge clk);
      if (ov[0] === 1'b1 && !taken) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0d expected=none", od0);
          out_ready = 1'b1;
          continue;
        end
        e = q.pop_front();
        chk("dp_acc32_sat", longint'(od0), e.d0);
        chk("ovf_acc32_sat", longint'(oo[0]), longint'(e.o0));
        chk("valid_acc16_sat", longint'(ov[1]), 1);
        chk("dp_acc16_sat", longint'(od1), e.d1);
        chk("ovf_acc16_sat", longint'(oo[1]), longint'(e.o1));
        chk("valid_acc16_wrap", longint'(ov[2]), 1);
        chk("dp_acc16_wrap", longint'(od2), e.d2);
        chk("ovf_acc16_wrap", longint'(oo[2]), longint'(e.o2));
        taken = 1'b1;
        hold = (force_hold >= 0) ? force_hold : int'($urandom_range(3));
        force_hold = -1;
      end else if (taken) begin
        chk("hold_out_valid", longint'(ov[0]), 1);
        chk("hold_out_dp", longint'(od0), e.d0);
        chk("hold_cfg_ready", longint'(cr[0]), 0);
        chk("hold_in_ready", longint'(ir[0]), 0);
      end
      if (taken) begin
        if (hold == 0) begin
          out_ready = 1'b1;
          taken = 1'b0;
        end else begin
          out_ready = 1'b0;
          hold--;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    int bud;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset");
    chk("reset_out_dp_acc16", longint'(od1), 0);

    // dot([1,2,3,4],[5,6,7,8]) = 70
    for (int i = 0; i < 4; i++) begin
      xv[i] = i + 1;
      wv[i] = i + 5;
    end
    run_job(4, 0, -1, -1);

    // len 6: lanes 2,3 of second chunk carry junk that must be masked
    for (int i = 0; i < 8; i++) begin
      xv[i] = (i < 4) ? 1 : ((i < 6) ? 3 : 99);
      wv[i] = (i < 4) ? 2 : ((i < 6) ? -1 : 99);
    end
    run_job(6, 0, -1, -1);

    // four (-128*-128) products overflow a 16-bit accumulator
    for (int i = 0; i < 4; i++) begin
      xv[i] = -128;
      wv[i] = -128;
    end
    run_job(4, 0, -1, -1);

    run_job(0, 0, -1, -1);
    fill_rand();
    run_job(64, 30, -1, -1);
    fill_rand();
    run_job(8, 0, -1, 5);
    fill_rand();
    run_job(70, 20, -1, -1);
    fill_rand();
    run_job(16, 0, 2, -1);
    fill_rand();
    run_job(4, 0, -1, -1);

    repeat (20) begin
      fill_rand();
      run_job(int'($urandom_range(MAX_LEN)),
              int'($urandom_range(50)), -1, -1);
    end

    bud = 0;
    while ((q.size() != 0 || taken) && bud < 300) begin
      @(negedge clk);
      bud++;
    end
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
